// File: rtl/cpu_defs.sv
// Shared definitions for the fetch/decode/sequence controller: opcodes, state encoding,
// instruction field positions and the immediate sign-extension helper.
package cpu_defs;

    // Opcodes; anything with opcode[5] == 0 is an ALU-class opcode handled by the regfile
    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_LDI  = 6'b010000;
    localparam logic [5:0] OP_LUI  = 6'b010001;
    localparam logic [5:0] OP_LB   = 6'b011010;
    localparam logic [5:0] OP_SB   = 6'b011011;
    localparam logic [5:0] OP_BEQ  = 6'b011110;
    localparam logic [5:0] OP_BLT  = 6'b011111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Instruction field positions (LSB of each field)
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned R1_LSB  = 21;
    localparam int unsigned R2_LSB  = 16;
    localparam int unsigned R3_LSB  = 11;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StBranch,
        StHalt,
        StTrap
    } cu_state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction slicer: fields, sign-extended immediate and class flags.
module instr_decoder
    import cpu_defs::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  opcode_o,
    output logic [4:0]  reg1_o,
    output logic [4:0]  reg2_o,
    output logic [4:0]  reg3_o,
    output logic [31:0] imm_o,
    output logic        legal_o,
    output logic        is_branch_o,
    output logic        is_mem_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        is_halt_o,
    output logic        writes_reg_o
);

    logic alu_class;
    logic imm_op;

    // Slice fields and classify the opcode
    always_comb begin
        opcode_o     = instr_i[OPC_LSB +: 6];
        reg1_o       = instr_i[R1_LSB +: 5];
        reg2_o       = instr_i[R2_LSB +: 5];
        reg3_o       = instr_i[R3_LSB +: 5];
        imm_o        = sign_ext16(instr_i[IMM_LSB +: 16]);
        alu_class    = (opcode_o[5] == OP_ALU[5]);
        imm_op       = (opcode_o == OP_LDI) || (opcode_o == OP_LUI);
        is_load_o    = (opcode_o == OP_LB);
        is_store_o   = (opcode_o == OP_SB);
        is_mem_o     = is_load_o || is_store_o;
        is_branch_o  = (opcode_o == OP_BEQ) || (opcode_o == OP_BLT);
        is_halt_o    = (opcode_o == OP_HALT);
        legal_o      = alu_class || is_halt_o;
        writes_reg_o = imm_op || is_load_o || (alu_class && !is_branch_o && !is_mem_o);
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/sequence controller driving the register file, ALU and data memory.
// Owns the PC; register read and write strobes are issued in distinct states so never overlap.
module control_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        instr_req,
    output logic [31:0] pc,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic        reg_read,
    output logic        reg_write,
    output logic [5:0]  opcode,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic [4:0]  reg3,
    output logic [31:0] imm,
    output logic        alu_en,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        wb_sel,
    output logic        halted,
    output logic        trap
);

    cu_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic legal, is_branch, is_mem, is_load, is_store, is_halt, writes_reg;

    instr_decoder u_decoder (
        .instr_i      (instr_q),
        .opcode_o     (opcode),
        .reg1_o       (reg1),
        .reg2_o       (reg2),
        .reg3_o       (reg3),
        .imm_o        (imm),
        .legal_o      (legal),
        .is_branch_o  (is_branch),
        .is_mem_o     (is_mem),
        .is_load_o    (is_load),
        .is_store_o   (is_store),
        .is_halt_o    (is_halt),
        .writes_reg_o (writes_reg)
    );

    assign pc = pc_q;

    // State, PC, latched instruction and memory-wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore strobes; the counter only runs while waiting in MEM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        cnt_d     = '0;
        instr_req = 1'b0;
        reg_read  = 1'b0;
        reg_write = 1'b0;
        alu_en    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        wb_sel    = 1'b0;
        halted    = 1'b0;
        trap      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    instr_d = instr_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                reg_read = 1'b1;
                state_d  = legal ? StExec : StTrap;
            end
            StExec: begin
                alu_en = 1'b1;
                if (is_branch)    state_d = StBranch;
                else if (is_mem)  state_d = StMem;
                else if (is_halt) state_d = StHalt;
                else              state_d = StWb;
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                // An ack on the final allowed cycle still completes the access
                if (mem_ack) begin
                    if (is_store) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (cnt_q == (MEM_TIMEOUT - 8'd1)) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb: begin
                reg_write = writes_reg;
                wb_sel    = is_load;
                pc_d      = pc_q + 32'd4;
                state_d   = StFetch;
            end
            StBranch: begin
                pc_d    = branch_taken ? (pc_q + 32'd4 + {imm[29:0], 2'b00}) : (pc_q + 32'd4);
                state_d = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            StTrap: begin
                trap = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit. Inputs are driven and outputs sampled on
// the falling edge; the DUT state changes on the rising edge.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = '0;
    logic        branch_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic        instr_req, reg_read, reg_write, alu_en, mem_req, mem_we, wb_sel, halted, trap;
    logic [31:0] pc, imm;
    logic [5:0]  opcode;
    logic [4:0]  reg1, reg2, reg3;
    logic [8:0]  strobes;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] I_LDI  = 32'h4020_0005;
    localparam logic [31:0] I_ALU  = 32'h0022_1800;
    localparam logic [31:0] I_LB   = 32'h6824_0010;
    localparam logic [31:0] I_SB   = 32'h6C00_0000;
    localparam logic [31:0] I_ILL  = 32'hA800_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    always #5 clk = ~clk;

    assign strobes = {instr_req, reg_read, reg_write, alu_en, mem_req, mem_we, wb_sel, halted,
                      trap};

    control_unit #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (8'd255)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .instr_req    (instr_req),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .opcode       (opcode),
        .reg1         (reg1),
        .reg2         (reg2),
        .reg3         (reg3),
        .imm          (imm),
        .alu_en       (alu_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .trap         (trap)
    );

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        reset_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr_data = '0;
        branch_taken = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // From FETCH, run one LDI to the next FETCH (pc += 4)
    task automatic run_ldi;
        instr_valid = 1'b1; instr_data = I_LDI; start = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (strobes !== 9'b0) begin
            tests_failed++; $display("FAIL reset_strobes: got %b want %b", strobes, 9'b0);
        end
        tests_run++;
        if (pc !== 32'h0) begin
            tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        tests_run++;
        if ({opcode, imm} !== 38'h0) begin
            tests_failed++; $display("FAIL reset_fields: got %h want 0", {opcode, imm});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (strobes !== 9'b0) begin
            tests_failed++; $display("FAIL idle_hold: got %b want %b", strobes, 9'b0);
        end
    endtask

    task automatic test_ldi;
        start = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({instr_req, pc} !== {1'b1, 32'h0}) begin
            tests_failed++; $display("FAIL ldi_fetch: got %b/%h want 1/0", instr_req, pc);
        end
        instr_valid = 1'b1; instr_data = I_LDI; start = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        tests_run++;
        if ({reg_read, reg_write, instr_req} !== 3'b100) begin
            tests_failed++;
            $display("FAIL ldi_decode_strobes: got %b want 100", {reg_read, reg_write, instr_req});
        end
        tests_run++;
        if ({opcode, reg1, reg2, imm} !== {6'h10, 5'd1, 5'd0, 32'd5}) begin
            tests_failed++;
            $display("FAIL ldi_fields: got %h %h %h %h want 10 1 0 5", opcode, reg1, reg2, imm);
        end
        @(negedge clk);
        tests_run++;
        if ({alu_en, reg_read, reg_write} !== 3'b100) begin
            tests_failed++;
            $display("FAIL ldi_exec: got %b want 100", {alu_en, reg_read, reg_write});
        end
        @(negedge clk);
        tests_run++;
        if ({reg_write, wb_sel, reg_read, pc} !== {3'b100, 32'h0}) begin
            tests_failed++;
            $display("FAIL ldi_wb: got %b pc %h want 100 pc 0", {reg_write, wb_sel, reg_read}, pc);
        end
        @(negedge clk);
        tests_run++;
        if ({instr_req, reg_write, pc} !== {2'b10, 32'h4}) begin
            tests_failed++;
            $display("FAIL ldi_next: got %b pc %h want 10 pc 4", {instr_req, reg_write}, pc);
        end
    endtask

    task automatic test_fetch_wait;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({instr_req, reg_read, pc} !== {2'b10, 32'h4}) begin
            tests_failed++;
            $display("FAIL fetch_wait: got %b pc %h want 10 pc 4", {instr_req, reg_read}, pc);
        end
        instr_valid = 1'b1; instr_data = I_ALU;
        @(negedge clk);
        instr_valid = 1'b0;
        tests_run++;
        if ({opcode, reg1, reg2, reg3, imm} !== {6'h0, 5'd1, 5'd2, 5'd3, 32'h1800}) begin
            tests_failed++;
            $display("FAIL alu_fields: got %h %h %h %h %h want 0 1 2 3 1800",
                     opcode, reg1, reg2, reg3, imm);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (reg_write !== 1'b1) begin
            tests_failed++; $display("FAIL alu_wb: got %b want 1", reg_write);
        end
        @(negedge clk);
        tests_run++;
        if (pc !== 32'h8) begin
            tests_failed++; $display("FAIL alu_pc: got %h want %h", pc, 32'h8);
        end
    endtask

    task automatic test_branch;
        logic [31:0] ins [2];
        logic        tk  [2];
        logic [31:0] exp_pc [2];
        logic        saw_write;
        ins[0] = 32'h7800_FFFE; tk[0] = 1'b1; exp_pc[0] = 32'h4;  // BEQ taken at 8
        ins[1] = 32'h7C00_FFFE; tk[1] = 1'b0; exp_pc[1] = 32'h8;  // BLT not taken at 4
        for (int i = 0; i < 2; i++) begin
            instr_valid = 1'b1; instr_data = ins[i];
            @(negedge clk);
            instr_valid = 1'b0;
            saw_write = reg_write;
            tests_run++;
            if (imm !== 32'hFFFF_FFFE) begin
                tests_failed++; $display("FAIL br%0d_imm: got %h want FFFFFFFE", i, imm);
            end
            @(negedge clk);
            saw_write |= reg_write;
            branch_taken = tk[i];
            @(negedge clk);
            saw_write |= reg_write;
            @(negedge clk);
            branch_taken = 1'b0;
            saw_write |= reg_write;
            tests_run++;
            if ({instr_req, pc} !== {1'b1, exp_pc[i]}) begin
                tests_failed++;
                $display("FAIL br%0d_pc: got %b/%h want 1/%h", i, instr_req, pc, exp_pc[i]);
            end
            tests_run++;
            if (saw_write !== 1'b0) begin
                tests_failed++; $display("FAIL br%0d_no_write: got %b want 0", i, saw_write);
            end
        end
    endtask

    task automatic test_lb;
        int mem_cycles = 0;
        int we_cycles = 0;
        instr_valid = 1'b1; instr_data = I_LB;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_cycles += int'(mem_req);
            we_cycles  += int'(mem_we);
            if (k == 2) mem_ack = 1'b1;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        tests_run++;
        if ({mem_cycles, we_cycles} !== {32'd3, 32'd0}) begin
            tests_failed++;
            $display("FAIL lb_mem_req: got req %0d we %0d want req 3 we 0", mem_cycles, we_cycles);
        end
        tests_run++;
        if ({reg_write, wb_sel, mem_req, pc} !== {3'b110, 32'h8}) begin
            tests_failed++;
            $display("FAIL lb_wb: got %b pc %h want 110 pc 8", {reg_write, wb_sel, mem_req}, pc);
        end
        @(negedge clk);
        tests_run++;
        if (pc !== 32'hC) begin
            tests_failed++; $display("FAIL lb_pc: got %h want %h", pc, 32'hC);
        end
    endtask

    task automatic test_sb_timeout;
        int req_cycles = 0;
        int we_cycles = 0;
        instr_valid = 1'b1; instr_data = I_SB;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (trap) break;
            req_cycles += int'(mem_req);
            we_cycles  += int'(mem_we);
        end
        tests_run++;
        if ({req_cycles, we_cycles} !== {32'd255, 32'd255}) begin
            tests_failed++;
            $display("FAIL sb_timeout_len: got req %0d we %0d want 255 255", req_cycles, we_cycles);
        end
        tests_run++;
        if ({trap, mem_req, reg_write, pc} !== {3'b100, 32'hC}) begin
            tests_failed++;
            $display("FAIL sb_trap: got %b pc %h want 100 pc C", {trap, mem_req, reg_write}, pc);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if ({trap, instr_req, pc} !== {2'b10, 32'hC}) begin
            tests_failed++;
            $display("FAIL sb_trap_sticky: got %b pc %h want 10 pc C", {trap, instr_req}, pc);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        instr_valid = 1'b1; instr_data = I_ILL; start = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        tests_run++;
        if (reg_read !== 1'b1) begin
            tests_failed++; $display("FAIL ill_decode: got %b want 1", reg_read);
        end
        @(negedge clk);
        tests_run++;
        if ({trap, alu_en, halted, pc} !== {3'b100, 32'h0}) begin
            tests_failed++;
            $display("FAIL ill_trap: got %b pc %h want 100 pc 0", {trap, alu_en, halted}, pc);
        end
    endtask

    task automatic test_halt;
        logic saw_req = 1'b0;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        instr_valid = 1'b1; instr_data = I_HALT;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({halted, trap, alu_en} !== 3'b100) begin
            tests_failed++; $display("FAIL halt_state: got %b want 100", {halted, trap, alu_en});
        end
        repeat (5) begin
            @(negedge clk);
            saw_req |= instr_req;
        end
        start = 1'b0;
        tests_run++;
        if ({saw_req, halted, pc} !== {2'b01, 32'h0}) begin
            tests_failed++;
            $display("FAIL halt_frozen: got req %b halted %b pc %h want 0 1 0", saw_req, halted, pc);
        end
    endtask

    task automatic test_reset_mid;
        logic saw_write;
        // Reset while waiting in MEM at pc 4
        do_reset();
        start = 1'b1;
        @(negedge clk);
        run_ldi();
        instr_valid = 1'b1; instr_data = I_LB;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_req, pc} !== {1'b1, 32'h4}) begin
            tests_failed++; $display("FAIL mid_mem_setup: got %b pc %h want 1 pc 4", mem_req, pc);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({strobes, pc} !== {9'b0, 32'h0}) begin
            tests_failed++; $display("FAIL mid_mem_reset: got %b pc %h want 0 pc 0", strobes, pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        saw_write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_write |= reg_write | instr_req;
        end
        tests_run++;
        if (saw_write !== 1'b0) begin
            tests_failed++; $display("FAIL mid_mem_after: got %b want 0", saw_write);
        end
        // Reset while in WB at pc 4
        start = 1'b1;
        @(negedge clk);
        run_ldi();
        instr_valid = 1'b1; instr_data = I_LDI;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({reg_write, pc} !== {1'b1, 32'h4}) begin
            tests_failed++; $display("FAIL mid_wb_setup: got %b pc %h want 1 pc 4", reg_write, pc);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({strobes, pc} !== {9'b0, 32'h0}) begin
            tests_failed++; $display("FAIL mid_wb_reset: got %b pc %h want 0 pc 0", strobes, pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        saw_write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_write |= reg_write;
        end
        tests_run++;
        if ({saw_write, pc} !== {1'b0, 32'h0}) begin
            tests_failed++; $display("FAIL mid_wb_after: got %b pc %h want 0 pc 0", saw_write, pc);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_fetch_wait();
        test_branch();
        test_lb();
        test_sb_timeout();
        test_illegal();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
